// File: rtl/bldc_phase_controller.sv
// rtl/bldc_phase_controller.sv - hall-commutated six-step BLDC phase controller; encoder block enabled by BLDC_ENCODER_EN
`timescale 1ns/1ps
module bldc_phase_controller #(
  parameter int MAX_DUTY_CYCLE      = 'h1FF,
  parameter int ENCODER_COUNT_WIDTH = 15,
  parameter int HALL_COUNT_WIDTH    = 7,
  parameter int DEAD_TIME           = 8
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           en,
  input  logic                           reset_enc_count,
  input  logic                           reset_hall_count,
  input  logic [8:0]                     duty_cycle,
  input  logic [1:0]                     enc,
  input  logic [2:0]                     hall,
  output logic [2:0]                     phaseH,
  output logic [2:0]                     phaseL,
  output logic [ENCODER_COUNT_WIDTH-1:0] enc_count,
  output logic [HALL_COUNT_WIDTH-1:0]    hall_count,
  output logic                           connected
);

  localparam int DUTY_CYCLE_WIDTH = $clog2(MAX_DUTY_CYCLE + 1);
  localparam int DTW = $clog2(DEAD_TIME + 2);
  localparam logic [2:0] NO_STEP = 3'd7;

  // Position of a hall code in the forward commutation sequence; 000/111 have none.
  function automatic logic [2:0] hall_step(input logic [2:0] h);
    case (h)
      3'b101:  hall_step = 3'd0;
      3'b100:  hall_step = 3'd1;
      3'b110:  hall_step = 3'd2;
      3'b010:  hall_step = 3'd3;
      3'b011:  hall_step = 3'd4;
      3'b001:  hall_step = 3'd5;
      default: hall_step = NO_STEP;
    endcase
  endfunction

  function automatic logic [2:0] next_step(input logic [2:0] s);
    next_step = (s == 3'd5) ? 3'd0 : s + 3'd1;
  endfunction

  logic [2:0] hall_s1, hall_s2, hall_d;
  logic [2:0] step_new, step_old;
  logic       hall_valid, old_valid, both_valid, step_fwd, step_rev, bad_step;
  logic       fault, drive_ok;

  assign step_new   = hall_step(hall_s2);
  assign step_old   = hall_step(hall_d);
  assign hall_valid = (step_new != NO_STEP);
  assign old_valid  = (step_old != NO_STEP);
  assign both_valid = hall_valid & old_valid & (hall_s2 != hall_d);
  assign step_fwd   = both_valid & (step_new == next_step(step_old));
  assign step_rev   = both_valid & (step_old == next_step(step_new));
  assign bad_step   = both_valid & ~step_fwd & ~step_rev;
  assign connected  = hall_valid & ~fault;
  // A bad step blocks drive in the same cycle it is seen, before the latch catches it.
  assign drive_ok   = en & hall_valid & ~fault & ~bad_step;

  // Hall synchronizer plus the previous synced code for step detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hall_s1 <= 3'b000;
      hall_s2 <= 3'b000;
      hall_d  <= 3'b000;
    end else begin
      hall_s1 <= hall;
      hall_s2 <= hall_s1;
      hall_d  <= hall_s2;
    end
  end

  // Fault latch: set by a jump between non-adjacent valid codes, cleared by dropping en
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      fault <= 1'b0;
    else if (!en)      fault <= 1'b0;
    else if (bad_step) fault <= 1'b1;
  end

  // Hall step counter, independent of en; the clear wins over a step
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)              hall_count <= '0;
    else if (reset_hall_count) hall_count <= '0;
    else if (step_fwd)         hall_count <= hall_count + HALL_COUNT_WIDTH'(1);
    else if (step_rev)         hall_count <= hall_count - HALL_COUNT_WIDTH'(1);
  end

  logic [DUTY_CYCLE_WIDTH-1:0] pwm_cnt, pwm_cmp;
  logic                        pwm_on;
  assign pwm_cmp = DUTY_CYCLE_WIDTH'({duty_cycle[7:0], 1'b0});
  assign pwm_on  = (pwm_cnt < pwm_cmp);

  // Free-running edge-aligned PWM counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                          pwm_cnt <= '0;
    else if (pwm_cnt == DUTY_CYCLE_WIDTH'(MAX_DUTY_CYCLE)) pwm_cnt <= '0;
    else                                                   pwm_cnt <= pwm_cnt + DUTY_CYCLE_WIDTH'(1);
  end

  logic [2:0] row_hi, row_lo, sel_hi, sel_lo, want_h, want_l, next_h, next_l;
  logic [DTW-1:0] h_run [3];
  logic [DTW-1:0] l_run [3];

  // Commutation table: pick the PWM'd phase and the grounded phase, swap for reverse
  always_comb begin
    row_hi = 3'b000;
    row_lo = 3'b000;
    case (step_new)
      3'd0: begin row_hi = 3'b001; row_lo = 3'b010; end
      3'd1: begin row_hi = 3'b001; row_lo = 3'b100; end
      3'd2: begin row_hi = 3'b010; row_lo = 3'b100; end
      3'd3: begin row_hi = 3'b010; row_lo = 3'b001; end
      3'd4: begin row_hi = 3'b100; row_lo = 3'b001; end
      3'd5: begin row_hi = 3'b100; row_lo = 3'b010; end
      default: ;
    endcase
    sel_hi = duty_cycle[8] ? row_lo : row_hi;
    sel_lo = duty_cycle[8] ? row_hi : row_lo;
    want_h = 3'b000;
    want_l = 3'b000;
    if (drive_ok) begin
      want_h = sel_hi & {3{pwm_on}};
      want_l = (sel_hi & {3{~pwm_on}}) | sel_lo;
    end
  end

  // Dead-time gate: a switch turns on only once its complement's off-run reaches DEAD_TIME
  always_comb begin
    next_h = 3'b000;
    next_l = 3'b000;
    for (int i = 0; i < 3; i++) begin
      next_h[i] = want_h[i] & ~phaseL[i] & (l_run[i] >= DTW'(DEAD_TIME));
      next_l[i] = want_l[i] & ~phaseH[i] & (h_run[i] >= DTW'(DEAD_TIME));
    end
  end

  // Gate outputs and per-switch saturating off-run counters (count includes the current cycle)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phaseH <= 3'b000;
      phaseL <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        h_run[i] <= '0;
        l_run[i] <= '0;
      end
    end else begin
      phaseH <= next_h;
      phaseL <= next_l;
      for (int i = 0; i < 3; i++) begin
        if (next_h[i])                      h_run[i] <= '0;
        else if (h_run[i] != DTW'(DEAD_TIME)) h_run[i] <= h_run[i] + DTW'(1);
        if (next_l[i])                      l_run[i] <= '0;
        else if (l_run[i] != DTW'(DEAD_TIME)) l_run[i] <= l_run[i] + DTW'(1);
      end
    end
  end

`ifdef BLDC_ENCODER_EN
  logic [1:0] enc_s1, enc_s2, enc_d, enc_diff;

  // Gray position {B, B^A}: 00,01,11,10 map to 0,1,2,3
  function automatic logic [1:0] enc_pos(input logic [1:0] e);
    enc_pos = {e[1], e[1] ^ e[0]};
  endfunction

  assign enc_diff = enc_pos(enc_s2) - enc_pos(enc_d);

  // Encoder synchronizer and previous synced state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enc_s1 <= 2'b00;
      enc_s2 <= 2'b00;
      enc_d  <= 2'b00;
    end else begin
      enc_s1 <= enc;
      enc_s2 <= enc_s1;
      enc_d  <= enc_s2;
    end
  end

  // x4 quadrature counter; a two-bit jump (diff 2) is ambiguous and ignored
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)              enc_count <= '0;
    else if (reset_enc_count)  enc_count <= '0;
    else if (enc_diff == 2'd1) enc_count <= enc_count + ENCODER_COUNT_WIDTH'(1);
    else if (enc_diff == 2'd3) enc_count <= enc_count - ENCODER_COUNT_WIDTH'(1);
  end
`else
  logic unused_enc;
  assign unused_enc = ^{enc, reset_enc_count};
  assign enc_count  = '0;
`endif

endmodule

// File: tb/tb_bldc_phase_controller.sv
// tb/tb_bldc_phase_controller.sv - scoreboard bench for bldc_phase_controller
`timescale 1ns/1ps
module tb_bldc_phase_controller;

  localparam int DT = 8;
  localparam int K_PH = 0, K_PL = 1, K_HC = 2, K_EC = 3, K_CONN = 4, K_WIN = 5;

  logic        clk = 1'b0;
  logic        reset_n, en, reset_enc_count, reset_hall_count;
  logic [8:0]  duty_cycle;
  logic [1:0]  enc;
  logic [2:0]  hall;
  logic [2:0]  phaseH, phaseL;
  logic [14:0] enc_count;
  logic [6:0]  hall_count;
  logic        connected;

  bldc_phase_controller dut (
    .clk(clk), .reset_n(reset_n), .en(en),
    .reset_enc_count(reset_enc_count), .reset_hall_count(reset_hall_count),
    .duty_cycle(duty_cycle), .enc(enc), .hall(hall),
    .phaseH(phaseH), .phaseL(phaseL),
    .enc_count(enc_count), .hall_count(hall_count), .connected(connected)
  );

  always #5 clk = ~clk;

  typedef struct {
    int    kind;
    int    idx;
    int    mask;
    int    v1;
    int    v2;
    string name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   busy = 1'b0;
  int   win_h, win_l;
  int   lrun[3];
  int   hrun[3];
  logic [2:0] prev_h = 3'b000;
  logic [2:0] prev_l = 3'b000;

  task automatic push_exp(input int kind, input int idx, input int mask,
                          input int v1, input int v2, input string name);
    exp_t e;
    e.kind = kind; e.idx = idx; e.mask = mask; e.v1 = v1; e.v2 = v2; e.name = name;
    exp_q.push_back(e);
  endtask

  // One negedge sample: overlap and dead-time invariants plus window accumulation
  task automatic tick();
    @(negedge clk);
    checks++;
    if ((phaseH & phaseL) != 3'b000) begin
      errors++;
      $display("FAIL overlap got H=%b L=%b want no common bit", phaseH, phaseL);
    end
    for (int i = 0; i < 3; i++) begin
      if (phaseH[i] && !prev_h[i]) begin
        checks++;
        if (lrun[i] < DT) begin
          errors++;
          $display("FAIL dead_time_h%0d got %0d want >=%0d", i, lrun[i], DT);
        end
      end
      if (phaseL[i] && !prev_l[i]) begin
        checks++;
        if (hrun[i] < DT) begin
          errors++;
          $display("FAIL dead_time_l%0d got %0d want >=%0d", i, hrun[i], DT);
        end
      end
      lrun[i] = phaseL[i] ? 0 : ((lrun[i] < 1000) ? lrun[i] + 1 : lrun[i]);
      hrun[i] = phaseH[i] ? 0 : ((hrun[i] < 1000) ? hrun[i] + 1 : hrun[i]);
    end
    win_h += int'(phaseH[0] & 1'b1) * 0;
    prev_h = phaseH;
    prev_l = phaseL;
  endtask

  // Monitor: pops expectations and compares against what the DUT presents
  initial begin : monitor
    exp_t e;
    int   got;
    for (int i = 0; i < 3; i++) begin lrun[i] = 0; hrun[i] = 0; end
    forever begin
      tick();
      if (exp_q.size() > 0) begin
        busy = 1'b1;
        e = exp_q.pop_front();
        if (e.kind == K_WIN) begin
          win_h = 0;
          win_l = 0;
          for (int k = 0; k < 512; k++) begin
            tick();
            if (phaseH[e.idx]) win_h++;
            if (phaseL[e.idx]) win_l++;
          end
          checks += 2;
          if (win_h != e.v1) begin
            errors++;
            $display("FAIL %s_high got %0d want %0d", e.name, win_h, e.v1);
          end
          if (win_l != e.v2) begin
            errors++;
            $display("FAIL %s_low got %0d want %0d", e.name, win_l, e.v2);
          end
        end else begin
          case (e.kind)
            K_PH:    got = int'(phaseH) & e.mask;
            K_PL:    got = int'(phaseL) & e.mask;
            K_HC:    got = int'(hall_count);
            K_EC:    got = int'(enc_count);
            default: got = int'(connected);
          endcase
          checks++;
          if (got != e.v1) begin
            errors++;
            $display("FAIL %s got %0d want %0d", e.name, got, e.v1);
          end
        end
        busy = 1'b0;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((exp_q.size() > 0 || busy) && k < 5000) begin
      @(posedge clk);
      k++;
    end
    if (exp_q.size() > 0 || busy) begin
      $display("FAIL drain_timeout got %0d pending want 0", exp_q.size());
      $fatal(1);
    end
    #1;
  endtask

  task automatic set_hall(input logic [2:0] h, input int n);
    hall = h;
    cyc(n);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin : stimulus
    reset_n = 1'b0; en = 1'b0; reset_enc_count = 1'b0; reset_hall_count = 1'b0;
    duty_cycle = 9'h000; enc = 2'b00; hall = 3'b000;
    cyc(4);
    push_exp(K_PH, 0, 7, 0, 0, "rst_phaseH");
    push_exp(K_PL, 0, 7, 0, 0, "rst_phaseL");
    push_exp(K_HC, 0, 0, 0, 0, "rst_hall_count");
    push_exp(K_EC, 0, 0, 0, 0, "rst_enc_count");
    push_exp(K_CONN, 0, 0, 0, 0, "rst_connected");
    drain();
    reset_n = 1'b1;
    cyc(2);

    // Forward, half duty, row 101: A PWM'd, B grounded, C floating
    hall = 3'b101; duty_cycle = 9'h080; en = 1'b1;
    cyc(600);
    push_exp(K_PH, 0, 3'b110, 0, 0, "fwd128_phaseH_bc");
    push_exp(K_PL, 0, 3'b110, 3'b010, 0, "fwd128_phaseL_bc");
    push_exp(K_CONN, 0, 0, 1, 0, "fwd128_connected");
    push_exp(K_WIN, 0, 0, 512 / 2 - DT, 512 / 2 - DT, "fwd128_a");
    drain();

    set_hall(3'b100, 20);
    push_exp(K_PH, 0, 3'b110, 0, 0, "row100_phaseH_bc");
    push_exp(K_PL, 0, 3'b110, 3'b100, 0, "row100_phaseL_bc");
    push_exp(K_HC, 0, 0, 1, 0, "hall_count_1");
    drain();

    set_hall(3'b110, 10);
    set_hall(3'b010, 10);
    push_exp(K_HC, 0, 0, 3, 0, "hall_count_3");
    drain();

    set_hall(3'b110, 10);
    set_hall(3'b100, 10);
    set_hall(3'b101, 10);
    push_exp(K_HC, 0, 0, 0, 0, "hall_count_back_0");
    drain();

    // Reverse: row 101 swaps to B PWM'd, A grounded
    duty_cycle = 9'h180;
    cyc(600);
    push_exp(K_PH, 0, 3'b101, 0, 0, "rev_phaseH_ac");
    push_exp(K_PL, 0, 3'b101, 3'b001, 0, "rev_phaseL_ac");
    push_exp(K_WIN, 1, 0, 512 / 2 - DT, 512 / 2 - DT, "rev128_b");
    drain();

    // Full magnitude: low side never meets its dead time, high side needs none
    duty_cycle = 9'h0FF;
    cyc(600);
    push_exp(K_WIN, 0, 0, 510, 0, "fwd255_a");
    drain();

    duty_cycle = 9'h000;
    cyc(600);
    push_exp(K_WIN, 0, 0, 0, 512, "fwd0_a");
    drain();

    set_hall(3'b111, 10);
    push_exp(K_CONN, 0, 0, 0, 0, "hall111_connected");
    push_exp(K_PH, 0, 7, 0, 0, "hall111_phaseH");
    push_exp(K_PL, 0, 7, 0, 0, "hall111_phaseL");
    push_exp(K_HC, 0, 0, 0, 0, "hall111_count");
    drain();
    set_hall(3'b101, 10);
    push_exp(K_CONN, 0, 0, 1, 0, "hall_recover_connected");
    drain();

    duty_cycle = 9'h080;
    set_hall(3'b010, 10);
    push_exp(K_CONN, 0, 0, 0, 0, "fault_connected");
    push_exp(K_PH, 0, 7, 0, 0, "fault_phaseH");
    push_exp(K_PL, 0, 7, 0, 0, "fault_phaseL");
    push_exp(K_HC, 0, 0, 0, 0, "fault_count");
    drain();

    en = 1'b0;
    cyc(5);
    push_exp(K_CONN, 0, 0, 1, 0, "fault_clear_connected");
    drain();

    set_hall(3'b011, 10);
    push_exp(K_HC, 0, 0, 1, 0, "count_with_en_low");
    drain();
    reset_hall_count = 1'b1;
    cyc(1);
    reset_hall_count = 1'b0;
    cyc(2);
    push_exp(K_HC, 0, 0, 0, 0, "hall_count_cleared");
    drain();

`ifdef BLDC_ENCODER_EN
    enc = 2'b01; cyc(6);
    enc = 2'b11; cyc(6);
    enc = 2'b10; cyc(6);
    enc = 2'b00; cyc(6);
    push_exp(K_EC, 0, 0, 4, 0, "enc_fwd_4");
    drain();
    enc = 2'b10; cyc(6);
    enc = 2'b11; cyc(6);
    enc = 2'b01; cyc(6);
    enc = 2'b00; cyc(6);
    push_exp(K_EC, 0, 0, 0, 0, "enc_rev_0");
    drain();
    enc = 2'b11; cyc(6);
    push_exp(K_EC, 0, 0, 0, 0, "enc_double_jump");
    drain();
    enc = 2'b00; cyc(6);
    enc = 2'b10; cyc(6);
    push_exp(K_EC, 0, 0, 32767, 0, "enc_underflow");
    drain();
    // Clear asserted exactly in the cycle the synced step is counted
    enc = 2'b11; cyc(1);
    cyc(1);
    reset_enc_count = 1'b1; cyc(1);
    reset_enc_count = 1'b0; cyc(4);
    push_exp(K_EC, 0, 0, 0, 0, "enc_clear_wins");
    drain();
    enc = 2'b01; cyc(6);
    push_exp(K_EC, 0, 0, 32767, 0, "enc_after_clear");
    drain();
`else
    enc = 2'b01; cyc(6);
    enc = 2'b11; cyc(6);
    push_exp(K_EC, 0, 0, 0, 0, "enc_disabled");
    drain();
`endif

    en = 1'b1;
    set_hall(3'b001, 300);
    push_exp(K_HC, 0, 0, 1, 0, "pre_reset_count");
    push_exp(K_CONN, 0, 0, 1, 0, "pre_reset_connected");
    drain();
    reset_n = 1'b0;
    #2;
    push_exp(K_PH, 0, 7, 0, 0, "midrun_rst_phaseH");
    push_exp(K_PL, 0, 7, 0, 0, "midrun_rst_phaseL");
    push_exp(K_HC, 0, 0, 0, 0, "midrun_rst_hall_count");
    push_exp(K_EC, 0, 0, 0, 0, "midrun_rst_enc_count");
    push_exp(K_CONN, 0, 0, 0, 0, "midrun_rst_connected");
    drain();
    reset_n = 1'b1;
    cyc(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
